// File: rtl/max_scan_if.sv
// max_scan_if: handshake/result bundle for max_scan_ctrl.
//   start, in_valid, in_data        : requester -> scanner
//   in_ready, busy, done            : scanner status
//   max_value, max_index, is_unique : result of the last completed scan
// The "unique" result is carried as is_unique because unique is a
// reserved word in SystemVerilog.
interface max_scan_if #(
    parameter int IDX_W = 2
);
    logic             start;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [31:0]      max_value;
    logic [IDX_W-1:0] max_index;
    logic             is_unique;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, busy, done, max_value, max_index, is_unique
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, busy, done, max_value, max_index, is_unique
    );
endinterface

// File: rtl/max_scan_ctrl.sv
// max_scan_ctrl: finds the float32 element of largest magnitude in a scan
// of N elements, reporting its original bits, arrival index, and whether
// the maximum magnitude occurred only once.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : max_scan_if.slave (start / in_valid / in_data in;
//           in_ready / busy / done / max_value / max_index / is_unique out)
module max_scan_ctrl #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    max_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] count;
    logic [31:0]      wmax;
    logic [IDX_W-1:0] widx;
    logic             wtie;

    logic [31:0]      res_max;
    logic [IDX_W-1:0] res_idx;
    logic             res_uniq;

    logic [31:0]      nmax;
    logic [IDX_W-1:0] nidx;
    logic             ntie;
    logic             accept;

    assign accept = (state == LOAD) && bus.in_valid;

    // Working values after folding in the current element. Bits [30:0]
    // compared as one unsigned number order by exponent, then mantissa,
    // which gives the raw-magnitude ordering with the sign dropped.
    always_comb begin
        nmax = wmax;
        nidx = widx;
        ntie = wtie;
        if (count == '0) begin
            nmax = bus.in_data;
            nidx = '0;
            ntie = 1'b0;
        end else if (bus.in_data[30:0] > wmax[30:0]) begin
            nmax = bus.in_data;
            nidx = count;
            ntie = 1'b0;
        end else if (bus.in_data[30:0] == wmax[30:0]) begin
            ntie = 1'b1;  // earliest element keeps the index
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            wmax     <= '0;
            widx     <= '0;
            wtie     <= 1'b0;
            res_max  <= '0;
            res_idx  <= '0;
            res_uniq <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_valid is ignored here, even alongside start
                    if (bus.start) begin
                        state <= LOAD;
                        count <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wmax <= nmax;
                        widx <= nidx;
                        wtie <= ntie;
                        if (count == IDX_W'(N - 1)) begin
                            // Results are published only here, so they
                            // never expose a partial scan.
                            state    <= DONE;
                            res_max  <= nmax;
                            res_idx  <= nidx;
                            res_uniq <= ~ntie;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.max_value = res_max;
    assign bus.max_index = res_idx;
    assign bus.is_unique = res_uniq;
endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb_max_scan_ctrl: directed and randomized scans of max_scan_ctrl (N=4),
// results compared against a whole-array reference computation.
module tb_max_scan_ctrl;
    localparam int N     = 4;
    localparam int IDX_W = 2;

    typedef logic [31:0] vec_t [N];

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   done_cnt;

    logic [31:0]      last_mv;
    logic [IDX_W-1:0] last_mi;
    logic             last_u;

    max_scan_if #(.IDX_W(IDX_W)) bus ();

    max_scan_ctrl #(.N(N), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: maximum of the whole scan by magnitude, first occurrence,
    // uniqueness = exactly one element at that magnitude.
    function automatic void ref_scan(input vec_t d, output logic [31:0] mv,
                                     output logic [IDX_W-1:0] mi, output logic u);
        int best;
        int hits;
        best = 0;
        for (int i = 1; i < N; i++)
            if (d[i][30:0] > d[best][30:0]) best = i;
        hits = 0;
        for (int i = 0; i < N; i++)
            if (d[i][30:0] == d[best][30:0]) hits++;
        mv = d[best];
        mi = IDX_W'(best);
        u  = (hits == 1);
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.busy},     32'd0);
        check({tag, "_done"},  {31'd0, bus.done},     32'd0);
        check({tag, "_mv"},    bus.max_value,         32'd0);
        check({tag, "_mi"},    {30'd0, bus.max_index}, 32'd0);
        check({tag, "_u"},     {31'd0, bus.is_unique}, 32'd0);
    endtask

    // One complete scan. gap = idle cycles before each element, spam =
    // pulse start during LOAD, sv = assert in_valid with start in IDLE.
    task automatic run_scan(input string tag, input vec_t d, input int gap,
                            input bit spam, input bit sv);
        logic [31:0]      mv;
        logic [IDX_W-1:0] mi;
        logic             u;
        int               dc0;
        ref_scan(d, mv, mi, u);
        dc0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = sv; bus.in_data = 32'h7F7FFFFF;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check({tag, "_busy_load"}, {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.start = spam; bus.in_valid = 1'b0;
                @(negedge clk);
            end
            check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
            bus.start = spam; bus.in_valid = 1'b1; bus.in_data = d[i];
            @(negedge clk);
            if (i < N - 1) begin
                check({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
                check({tag, "_hold_mv"}, bus.max_value, last_mv);
            end
        end
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_mv"}, bus.max_value, mv);
        check({tag, "_mi"}, {30'd0, bus.max_index}, {30'd0, mi});
        check({tag, "_u"}, {31'd0, bus.is_unique}, {31'd0, u});
        @(negedge clk);
        check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_mv_held"}, bus.max_value, mv);
        @(negedge clk);
        check({tag, "_one_done"}, done_cnt - dc0, 32'd1);
        last_mv = mv; last_mi = mi; last_u = u;
    endtask

    initial begin
        vec_t v;
        vec_t pool;
        int   dc0;
        tests = 0; fails = 0; done_cnt = 0;
        last_mv = '0; last_mi = '0; last_u = 1'b0;
        rst_n = 1'b0; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        // reset wins over start/in_valid
        check_zero_outputs("reset");
        rst_n = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);

        v = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000};
        run_scan("basic", v, 0, 1'b0, 1'b0);
        v = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h00000000};
        run_scan("tie", v, 0, 1'b0, 1'b0);
        v = '{32'hC0A00000, 32'h40000000, 32'h3F800000, 32'h00000000};
        run_scan("sign", v, 0, 1'b0, 1'b0);
        v = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000};
        run_scan("gaps", v, 3, 1'b1, 1'b0);
        v = '{32'h3F800001, 32'h3F800003, 32'h3F800002, 32'h3F800000};
        run_scan("mant", v, 0, 1'b0, 1'b0);
        v = '{32'h00000001, 32'h00000000, 32'h80000000, 32'h00000002};
        run_scan("startvalid", v, 1, 1'b0, 1'b1);
        v = '{32'h7F800000, 32'h7FC00000, 32'hFFC00000, 32'h00000000};
        run_scan("nan", v, 0, 1'b0, 1'b0);

        // reset mid-LOAD discards the partial scan
        dc0 = done_cnt;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h7F000000;
        @(negedge clk); bus.in_data = 32'h7F000001;
        @(negedge clk); bus.in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check_zero_outputs("midreset");
        repeat (4) @(negedge clk);
        check("midreset_nodone", done_cnt - dc0, 32'd0);
        last_mv = '0; last_mi = '0; last_u = 1'b0;
        v = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        run_scan("after_rst", v, 0, 1'b0, 1'b0);

        // random scans drawn partly from a small pool to provoke ties
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) pool[i] = $urandom;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    v[i] = pool[$urandom_range(0, 1)] ^ {$urandom_range(0, 1) == 1, 31'd0};
                else
                    v[i] = $urandom;
            end
            run_scan($sformatf("rnd%0d", r), v, $urandom_range(0, 2),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/max_scan_ctrl.md
MAX_SCAN_CTRL -- requirements
Module: max_scan_ctrl

Interface
REQ-001 Parameter: N, default 4, number of float32 elements per scan (N >= 2).
REQ-002 Parameter: IDX_W, default 2, index width; SHALL satisfy 2^IDX_W >= N.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to begin a new scan; sampled only in IDLE.
REQ-006 in_valid  input  1  in_data carries a valid element.
REQ-007 in_data  input  32  IEEE-754 single-precision element.
REQ-008 in_ready  output  1  block accepts an element this cycle.
REQ-009 busy  output  1  high in LOAD and DONE states.
REQ-010 done  output  1  one-cycle pulse; scan result is valid.
REQ-011 max_value  output  32  largest element of the last completed scan, original bits including sign.
REQ-012 max_index  output  IDX_W  arrival position (0..N-1) of max_value.
REQ-013 unique  output  1  high when no other element in the scan equalled max_value in magnitude.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LOAD, DONE.
REQ-015 IDLE -> LOAD on start=1; count cleared to 0; result outputs unchanged on this edge.
REQ-016 in_ready SHALL equal 1 only in LOAD; an element is accepted when in_valid && in_ready.
REQ-017 The magnitude comparison SHALL use bits [30:23] (exponent) first, then [22:0] (mantissa) on exponent equality; sign bit [31] is ignored.
REQ-018 NaN, Inf, zero and denormals SHALL be compared as raw magnitude bit patterns; no special handling.
REQ-019 First accepted element (count=0): working max <= in_data, index <= 0, tie <= 0.
REQ-020 Later element, magnitude strictly greater: max <= in_data, index <= count, tie <= 0.
REQ-021 Later element, magnitude equal: max and index unchanged (earliest wins), tie <= 1.
REQ-022 Later element, magnitude smaller: no change.
REQ-023 count SHALL increment by 1 per accepted element; no change on cycles without acceptance (in_valid gaps allowed, no timeout).
REQ-024 Acceptance at count = N-1 SHALL move to DONE on the same edge; count does not wrap past N-1.
REQ-025 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-026 Latency: done asserts in the cycle immediately after the N-th element is accepted.
REQ-027 max_value, max_index and unique SHALL update only on entry to DONE and hold until the next DONE or reset; they never show partial results.
REQ-028 unique SHALL equal the inverted working tie flag at entry to DONE.
REQ-029 start while in LOAD or DONE SHALL be ignored; no restart, no error.
REQ-030 start and in_valid high together in IDLE: only start takes effect; in_data is not accepted that cycle.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, count=0, in_ready=0, busy=0, done=0, max_value=0, max_index=0, unique=0, working max/index/tie cleared.
REQ-032 Reset mid-LOAD SHALL discard the partial scan; no done pulse is generated for it.
REQ-033 Reset has priority over start and in_valid in the same cycle.

Verification (N=4)
REQ-034 start; stream 0x3F800000, 0x40400000, 0x40000000, 0x3F000000 back-to-back -> done one cycle after 4th accept, max_value=0x40400000, max_index=1, unique=1.
REQ-035 start; stream 0x40000000, 0x3F800000, 0x40000000, 0x00000000 -> max_value=0x40000000, max_index=0, unique=0.
REQ-036 start; stream 0xC0A00000, 0x40000000, 0x3F800000, 0x00000000 -> max_value=0xC0A00000, max_index=0, unique=1 (sign ignored).
REQ-037 start; in_valid gaps of 3 idle cycles between elements, plus start pulses during LOAD -> exactly one done, 4 accepts, result identical to gap-free run.
REQ-038 start; accept 2 elements; rst_n=0 one cycle -> IDLE, all outputs 0, no done; new scan 0x3F800000 x4 -> max_index=0, unique=0.
REQ-039 Same-exponent check: stream 0x3F800001, 0x3F800003, 0x3F800002, 0x3F800000 -> max_value=0x3F800003, max_index=1, unique=1.
